load_store_queue: RTL and testbench

- Parametrised in-order load/store queue that sits between the decoder/RF, the ROB and the memory controller.
- Holds up to DEPTH memory instructions and computes addresses as base + imm.
- Wakes operands from NUM_WB broadcast channels, issues loads from the head to memory over a valid/ready handshake, and exposes the head store to the ROB for commit.
- Adds over the current buffer: configurable depth, channel count and MMIO window; use of every slot; almost-full indication; a backpressured memory request.

---
 rtl/load_store_queue_pkg.sv | 36 +++
 rtl/lsq_wakeup_match.sv | 34 +++
 rtl/load_store_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: memory op encodings, the
// "operand ready" dependency tag, op classification helpers and default MMIO
// window settings.
package load_store_queue_pkg;

  localparam int unsigned LSQ_OP_W = 6;

  typedef enum logic [LSQ_OP_W-1:0] {
    OP_NONE = 6'd0,
    OP_LB   = 6'd1,
    OP_LH   = 6'd2,
    OP_LW   = 6'd3,
    OP_LBU  = 6'd4,
    OP_LHU  = 6'd5,
    OP_SB   = 6'd6,
    OP_SH   = 6'd7,
    OP_SW   = 6'd8
  } mem_op_e;

  // A dependency tag of all ones means the operand value is already present.
  // For the default ROB_W=4 the tag is 5 bits wide.
  localparam int unsigned DEF_ROB_W = 4;
  localparam logic [DEF_ROB_W:0] DEP_READY = '1;

  localparam logic [31:0] DEF_IO_BASE = 32'h0003_0000;
  localparam logic [31:0] DEF_IO_MASK = 32'hFFFF_0000;

  function automatic logic is_load(input logic [LSQ_OP_W-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [LSQ_OP_W-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/lsq_wakeup_match.sv
// Compares one dependency tag against every writeback broadcast channel.
//   dep       : pending tag {0, rob_id}; the all-ones ready tag never matches
//   wb_*      : NUM_WB broadcast channels (valid, packed ids, packed data)
//   hit/data  : a channel matched, and that channel's result
// When several channels match, the lowest-numbered channel wins.
module lsq_wakeup_match
  import load_store_queue_pkg::*;
#(
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic [ROB_W:0]           dep,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]  wb_id,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  output logic                     hit,
  output logic [XLEN-1:0]          data
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit  = 1'b0;
    data = '0;
    // Scan downwards so the last (lowest k) match overwrites the others.
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_valid[k] && (dep == {1'b0, wb_id[k*ROB_W +: ROB_W]})) begin
        hit  = 1'b1;
        data = wb_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue between decode, ROB and the memory controller.
//   clk/rst/rdy/flush/stall : clocking, async reset, global enable, flush, alloc block
//   wb_*                    : operand wakeup broadcasts
//   dec_*/op*_val/op*_dep   : new instruction from decode with merged operands
//   rob_head_id/rob_store_commit : ROB head tag and store retirement
//   mem_req_*               : registered load request, valid/ready handshake
//   front_*                 : head entry status (combinational)
//   lsq_*                   : occupancy and flags
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 8,
  parameter int unsigned     NUM_WB   = 2,
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ROB_W    = 4,
  parameter int unsigned     OP_W     = LSQ_OP_W,
  parameter int unsigned     AFULL_TH = DEPTH - 2,
  parameter logic [XLEN-1:0] IO_BASE  = XLEN'(DEF_IO_BASE),
  parameter logic [XLEN-1:0] IO_MASK  = XLEN'(DEF_IO_MASK),
  localparam int unsigned    DEP_W    = ROB_W + 1,
  localparam int unsigned    CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    stall,
  input  logic                    io_buffer_full,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*ROB_W-1:0] wb_id,
  input  logic [NUM_WB*XLEN-1:0]  wb_data,
  input  logic                    dec_valid,
  input  logic [OP_W-1:0]         dec_op,
  input  logic [XLEN-1:0]         dec_imm,
  input  logic [ROB_W-1:0]        dec_rob_id,
  input  logic [XLEN-1:0]         op1_val,
  input  logic [DEP_W-1:0]        op1_dep,
  input  logic [XLEN-1:0]         op2_val,
  input  logic [DEP_W-1:0]        op2_dep,
  input  logic [ROB_W-1:0]        rob_head_id,
  input  logic                    rob_store_commit,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [OP_W-1:0]         mem_req_op,
  output logic [XLEN-1:0]         mem_req_addr,
  output logic [ROB_W-1:0]        mem_req_id,
  output logic                    front_valid,
  output logic                    front_is_store,
  output logic                    front_ready,
  output logic [OP_W-1:0]         front_op,
  output logic [XLEN-1:0]         front_addr,
  output logic [XLEN-1:0]         front_data,
  output logic [ROB_W-1:0]        front_id,
  output logic [CNT_W-1:0]        lsq_count,
  output logic                    lsq_full,
  output logic                    lsq_empty,
  output logic                    lsq_almost_full
);

  localparam int unsigned    PTR_W     = $clog2(DEPTH);
  localparam logic [DEP_W-1:0] DEP_RDY = {DEP_W{1'b1}};

  // Control state (reset) and per-entry payload (not reset).
  logic [DEPTH-1:0] valid, issued;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [OP_W-1:0]  op     [DEPTH];
  logic [XLEN-1:0]  v1     [DEPTH];
  logic [XLEN-1:0]  v2     [DEPTH];
  logic [DEP_W-1:0] q1     [DEPTH];
  logic [DEP_W-1:0] q2     [DEPTH];
  logic [ROB_W-1:0] rob_id [DEPTH];

  // Per-entry wakeup matches.
  logic [DEPTH-1:0] q1_hit, q2_hit;
  logic [XLEN-1:0]  q1_data [DEPTH];
  logic [XLEN-1:0]  q2_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    lsq_wakeup_match #(.NUM_WB(NUM_WB), .ROB_W(ROB_W), .XLEN(XLEN)) u_q1 (
      .dep(q1[i]), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
      .hit(q1_hit[i]), .data(q1_data[i])
    );
    lsq_wakeup_match #(.NUM_WB(NUM_WB), .ROB_W(ROB_W), .XLEN(XLEN)) u_q2 (
      .dep(q2[i]), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
      .hit(q2_hit[i]), .data(q2_data[i])
    );
  end

  // Same-cycle bypass for operands arriving while the entry is allocated.
  logic            byp1_hit, byp2_hit;
  logic [XLEN-1:0] byp1_data, byp2_data;

  lsq_wakeup_match #(.NUM_WB(NUM_WB), .ROB_W(ROB_W), .XLEN(XLEN)) u_byp1 (
    .dep(op1_dep), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .hit(byp1_hit), .data(byp1_data)
  );
  lsq_wakeup_match #(.NUM_WB(NUM_WB), .ROB_W(ROB_W), .XLEN(XLEN)) u_byp2 (
    .dep(op2_dep), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .hit(byp2_hit), .data(byp2_data)
  );

  logic [XLEN-1:0]  alloc_v1, alloc_v2;
  logic [DEP_W-1:0] alloc_q1, alloc_q2;

  always_comb begin
    alloc_v1 = dec_imm;
    alloc_q1 = op1_dep;
    if (op1_dep == DEP_RDY) begin
      alloc_v1 = op1_val + dec_imm;
    end else if (byp1_hit) begin
      alloc_v1 = byp1_data + dec_imm;
      alloc_q1 = DEP_RDY;
    end
    alloc_v2 = op2_val;
    alloc_q2 = op2_dep;
    if (is_load(dec_op)) begin
      alloc_v2 = '0;
      alloc_q2 = DEP_RDY;
    end else if (op2_dep != DEP_RDY && byp2_hit) begin
      alloc_v2 = byp2_data;
      alloc_q2 = DEP_RDY;
    end
  end

  // Occupancy flags.
  assign lsq_count       = count;
  assign lsq_full        = (count == CNT_W'(DEPTH));
  assign lsq_empty       = (count == '0);
  assign lsq_almost_full = (count >= CNT_W'(AFULL_TH));

  // Head view.
  assign front_valid    = valid[head];
  assign front_op       = op[head];
  assign front_is_store = is_store(op[head]);
  assign front_ready    = (q1[head] == DEP_RDY) && (q2[head] == DEP_RDY);
  assign front_addr     = v1[head];
  assign front_data     = v2[head];
  assign front_id       = rob_id[head];

  logic alloc, deq, mem_fire, store_retire, issue, cand_mmio;
  logic [PTR_W-1:0] cand;

  assign alloc = rdy && !flush && !stall && dec_valid && !lsq_full &&
                 (is_load(dec_op) || is_store(dec_op));
  assign mem_fire     = rdy && mem_req_valid && mem_req_ready;
  assign store_retire = rdy && rob_store_commit && valid[head] && is_store(op[head]);
  assign deq          = !flush && (mem_fire || store_retire);

  // The outstanding request always belongs to the head, so when it is being
  // accepted the next candidate to issue is the entry behind it.
  assign cand      = mem_fire ? head + PTR_W'(1) : head;
  assign cand_mmio = ((v1[cand] & IO_MASK) == IO_BASE);
  assign issue = rdy && !flush && (!mem_req_valid || mem_fire) &&
                 valid[cand] && !issued[cand] && is_load(op[cand]) &&
                 (q1[cand] == DEP_RDY) &&
                 (!cand_mmio || (!io_buffer_full && rob_id[cand] == rob_head_id));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid         <= '0;
      issued        <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_op    <= '0;
      mem_req_addr  <= '0;
      mem_req_id    <= '0;
    end else if (rdy) begin
      // NOTE: sequential state uses non-blocking assignments so every update
      // in this block sees the pre-edge values of head, tail and count.
      if (flush) begin
        valid         <= '0;
        issued        <= '0;
        tail          <= head;
        count         <= '0;
        mem_req_valid <= 1'b0;
      end else begin
        if (deq) begin
          valid[head] <= 1'b0;
          head        <= head + PTR_W'(1);
        end
        if (alloc) begin
          valid[tail]  <= 1'b1;
          issued[tail] <= 1'b0;
          tail         <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(alloc) - CNT_W'(deq);
        if (issue) begin
          issued[cand]  <= 1'b1;
          mem_req_valid <= 1'b1;
          mem_req_op    <= op[cand];
          mem_req_addr  <= v1[cand];
          mem_req_id    <= rob_id[cand];
        end else if (mem_fire) begin
          mem_req_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: payload storage is not reset; an entry's contents are only read
  // while its valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && q1_hit[i]) begin
          q1[i] <= DEP_RDY;
          v1[i] <= v1[i] + q1_data[i];
        end
        if (valid[i] && q2_hit[i]) begin
          q2[i] <= DEP_RDY;
          v2[i] <= q2_data[i];
        end
      end
      if (alloc) begin
        op[tail]     <= dec_op;
        v1[tail]     <= alloc_v1;
        q1[tail]     <= alloc_q1;
        v2[tail]     <= alloc_v2;
        q2[tail]     <= alloc_q2;
        rob_id[tail] <= dec_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue with default parameters.
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  localparam logic [4:0] RDY_DEP = 5'h1F;

  logic        clk, rst, rdy, flush, stall, io_buffer_full;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [63:0] wb_data;
  logic        dec_valid;
  logic [5:0]  dec_op;
  logic [31:0] dec_imm;
  logic [3:0]  dec_rob_id;
  logic [31:0] op1_val, op2_val;
  logic [4:0]  op1_dep, op2_dep;
  logic [3:0]  rob_head_id;
  logic        rob_store_commit;
  logic        mem_req_valid, mem_req_ready;
  logic [5:0]  mem_req_op;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_id;
  logic        front_valid, front_is_store, front_ready;
  logic [5:0]  front_op;
  logic [31:0] front_addr, front_data;
  logic [3:0]  front_id;
  logic [3:0]  lsq_count;
  logic        lsq_full, lsq_empty, lsq_almost_full;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
    .io_buffer_full(io_buffer_full),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_imm(dec_imm), .dec_rob_id(dec_rob_id),
    .op1_val(op1_val), .op1_dep(op1_dep), .op2_val(op2_val), .op2_dep(op2_dep),
    .rob_head_id(rob_head_id), .rob_store_commit(rob_store_commit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_op(mem_req_op), .mem_req_addr(mem_req_addr), .mem_req_id(mem_req_id),
    .front_valid(front_valid), .front_is_store(front_is_store), .front_ready(front_ready),
    .front_op(front_op), .front_addr(front_addr), .front_data(front_data), .front_id(front_id),
    .lsq_count(lsq_count), .lsq_full(lsq_full), .lsq_empty(lsq_empty),
    .lsq_almost_full(lsq_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] imm, input logic [3:0] rid,
                          input logic [31:0] v1, input logic [4:0] d1,
                          input logic [31:0] v2, input logic [4:0] d2);
    dec_valid  = 1'b1;
    dec_op     = op;
    dec_imm    = imm;
    dec_rob_id = rid;
    op1_val    = v1;
    op1_dep    = d1;
    op2_val    = v2;
    op2_dep    = d2;
    tick();
    dec_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0; io_buffer_full = 1'b0;
    wb_valid = '0; wb_id = '0; wb_data = '0;
    dec_valid = 1'b0; dec_op = '0; dec_imm = '0; dec_rob_id = '0;
    op1_val = '0; op1_dep = RDY_DEP; op2_val = '0; op2_dep = RDY_DEP;
    rob_head_id = '0; rob_store_commit = 1'b0; mem_req_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_count", 64'(lsq_count), 0);
    check("rst_empty", 64'(lsq_empty), 1);
    check("rst_full", 64'(lsq_full), 0);
    check("rst_afull", 64'(lsq_almost_full), 0);
    check("rst_req_valid", 64'(mem_req_valid), 0);
    check("rst_req_addr", 64'(mem_req_addr), 0);
    check("rst_front_valid", 64'(front_valid), 0);
    #4 rst = 1'b0;
    tick();

    // LW with pending base (dep 3), woken by channel 1 with 0x100
    dispatch(OP_LW, 32'h4, 4'd1, 32'h0, 5'd3, 32'h0, RDY_DEP);
    check("lw_count", 64'(lsq_count), 1);
    check("lw_front_not_ready", 64'(front_ready), 0);
    wb_valid = 2'b10; wb_id = 8'h30; wb_data = {32'h100, 32'h0};
    tick();
    wb_valid = '0;
    check("wake_front_ready", 64'(front_ready), 1);
    check("wake_front_addr", 64'(front_addr), 32'h104);
    check("wake_no_req_yet", 64'(mem_req_valid), 0);
    tick();
    check("issue_valid", 64'(mem_req_valid), 1);
    check("issue_addr", 64'(mem_req_addr), 32'h104);
    check("issue_id", 64'(mem_req_id), 1);
    check("issue_op", 64'(mem_req_op), 64'(OP_LW));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 64'(mem_req_valid), 1);
      check("hold_addr", 64'(mem_req_addr), 32'h104);
      check("hold_count", 64'(lsq_count), 1);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("accept_count", 64'(lsq_count), 0);
    check("accept_valid", 64'(mem_req_valid), 0);

    // Two channels match the same tag: channel 0 (0x200) wins
    dispatch(OP_LW, 32'h10, 4'd2, 32'h0, 5'd2, 32'h0, RDY_DEP);
    wb_valid = 2'b11; wb_id = 8'h22; wb_data = {32'h300, 32'h200};
    tick();
    wb_valid = '0;
    check("prio_addr", 64'(front_addr), 32'h210);
    mem_req_ready = 1'b1;
    tick();
    check("prio_req_addr", 64'(mem_req_addr), 32'h210);
    check("prio_req_valid", 64'(mem_req_valid), 1);
    tick();
    mem_req_ready = 1'b0;
    check("prio_done_count", 64'(lsq_count), 0);
    check("prio_done_valid", 64'(mem_req_valid), 0);

    // Same-cycle bypass at allocation
    wb_valid = 2'b01; wb_id = 8'h04; wb_data = {32'h0, 32'h40};
    dispatch(OP_LW, 32'h8, 4'd3, 32'h0, 5'd4, 32'h0, RDY_DEP);
    wb_valid = '0;
    check("byp_front_ready", 64'(front_ready), 1);
    check("byp_front_addr", 64'(front_addr), 32'h48);
    tick();
    check("byp_req_addr", 64'(mem_req_addr), 32'h48);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("byp_done_count", 64'(lsq_count), 0);

    // MMIO load gated on ROB head and io_buffer_full
    rob_head_id = 4'd2;
    dispatch(OP_LW, 32'h0, 4'd5, 32'h30000, RDY_DEP, 32'h0, RDY_DEP);
    tick(); tick();
    check("mmio_wrong_head", 64'(mem_req_valid), 0);
    rob_head_id = 4'd5; io_buffer_full = 1'b1;
    tick(); tick();
    check("mmio_buf_full", 64'(mem_req_valid), 0);
    io_buffer_full = 1'b0;
    tick();
    check("mmio_issued", 64'(mem_req_valid), 1);
    check("mmio_addr", 64'(mem_req_addr), 32'h30000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rob_head_id = 4'd0;
    check("mmio_done_count", 64'(lsq_count), 0);
    check("ptr_head_4", 64'(dut.head), 4);

    // Blocked allocations: stall, rdy low, non-memory op
    stall = 1'b1;
    dispatch(OP_SW, 32'h0, 4'd0, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    stall = 1'b0;
    check("stall_count", 64'(lsq_count), 0);
    rdy = 1'b0;
    dispatch(OP_SW, 32'h0, 4'd0, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    rdy = 1'b1;
    check("rdy_low_count", 64'(lsq_count), 0);
    dispatch(OP_NONE, 32'h0, 4'd0, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    check("bad_op_count", 64'(lsq_count), 0);

    // Fill all eight slots with stores
    for (int i = 0; i < 8; i++) begin
      dispatch(OP_SW, 32'h0, 4'(i), 32'h1000 + 32'(i), RDY_DEP, 32'(i), RDY_DEP);
      check("fill_count", 64'(lsq_count), 64'(i + 1));
      check("fill_afull", 64'(lsq_almost_full), 64'(i + 1 >= 6));
      check("fill_full", 64'(lsq_full), 64'(i + 1 == 8));
    end
    dispatch(OP_SW, 32'h0, 4'd9, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    check("overfill_count", 64'(lsq_count), 8);
    check("overfill_tail", 64'(dut.tail), 4);
    check("front_is_store", 64'(front_is_store), 1);
    check("front_data", 64'(front_data), 0);

    // Store commit, then commit together with allocation across the wrap
    rob_store_commit = 1'b1;
    tick();
    check("commit_count", 64'(lsq_count), 7);
    check("commit_head", 64'(dut.head), 5);
    for (int j = 0; j < 4; j++) begin
      dispatch(OP_SH, 32'h0, 4'(j), 32'h2000, RDY_DEP, 32'h0, RDY_DEP);
      check("swap_count", 64'(lsq_count), 7);
      check("swap_head", 64'(dut.head), 64'((6 + j) % 8));
      check("swap_tail", 64'(dut.tail), 64'((5 + j) % 8));
    end
    rob_store_commit = 1'b0;

    // Flush an occupied queue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush1_count", 64'(lsq_count), 0);
    check("flush1_tail", 64'(dut.tail), 1);

    // Flush with a pending request and four entries
    dispatch(OP_LW, 32'h0, 4'd6, 32'h500, RDY_DEP, 32'h0, RDY_DEP);
    for (int i = 0; i < 3; i++) dispatch(OP_SB, 32'h0, 4'd7, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    check("pre_flush_count", 64'(lsq_count), 4);
    check("pre_flush_req", 64'(mem_req_valid), 1);
    check("pre_flush_addr", 64'(mem_req_addr), 32'h500);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_req", 64'(mem_req_valid), 0);
    check("flush2_count", 64'(lsq_count), 0);
    check("flush2_head", 64'(dut.head), 1);
    check("flush2_tail", 64'(dut.tail), 1);

    // Store commit with a load at the head is ignored
    dispatch(OP_LB, 32'h0, 4'd9, 32'h0, 5'd9, 32'h0, RDY_DEP);
    rob_store_commit = 1'b1;
    tick();
    rob_store_commit = 1'b0;
    check("commit_on_load", 64'(lsq_count), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Asynchronous reset mid-operation
    dispatch(OP_LW, 32'h0, 4'd7, 32'h600, RDY_DEP, 32'h0, RDY_DEP);
    dispatch(OP_SW, 32'h0, 4'd8, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    dispatch(OP_SW, 32'h0, 4'd9, 32'h0, RDY_DEP, 32'h0, RDY_DEP);
    check("pre_rst_count", 64'(lsq_count), 3);
    check("pre_rst_req", 64'(mem_req_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 64'(mem_req_valid), 0);
    check("async_rst_empty", 64'(lsq_empty), 1);
    check("async_rst_count", 64'(lsq_count), 0);
    check("async_rst_head", 64'(dut.head), 0);
    #2 rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
